// File: rtl/frame_downsample_writer.sv
// ============================================================================
// frame_downsample_writer : 2x2 box-average downsampler writing to frame RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_downsample_writer #(
  parameter int IN_W   = 160,
  parameter int IN_H   = 120,
  parameter int CW     = 10,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              write,
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  input  logic [3*CW-1:0]   pixel,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3*CW-1:0]   mem_data,
  output logic              busy,
  output logic              done
);

  localparam int          HALF_W = IN_W / 2;
  localparam int          LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int          SW     = CW + 1;
  localparam logic [8:0]  C_IN_W = 9'(IN_W);
  localparam logic [8:0]  C_IN_H = 9'(IN_H);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                fin_q, fin_d;
  logic [3*CW-1:0]     hold_q, hold_d;
  logic                mem_we_q, mem_we_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3*CW-1:0]     mem_data_q, mem_data_d;

  logic [3*SW-1:0]     lb_mem [HALF_W];
  logic [3*SW-1:0]     lb_rd_q;
  logic [3*SW-1:0]     lb_wdata;
  logic [3*CW-1:0]     avg_data;
  logic                lb_we, lb_re;
  logic [LB_AW-1:0]    lb_idx;
  logic                accept, last_beat;

  assign lb_idx    = x[LB_AW:1];
  assign last_beat = (x == 8'(IN_W - 1)) && (y == 8'(IN_H - 1));
  // fin_q blocks any beat arriving in the one cycle between the last write and S_IDLE
  assign accept    = write && (state_q == S_RUN) && !fin_q &&
                     ({1'b0, x} < C_IN_W) && ({1'b0, y} < C_IN_H);

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [CW+1:0] quad;
    assign lb_wdata[c*SW +: SW] = SW'(hold_q[c*CW +: CW]) + SW'(pixel[c*CW +: CW]);
    assign quad = (CW+2)'(lb_rd_q[c*SW +: SW]) + (CW+2)'(hold_q[c*CW +: CW])
                + (CW+2)'(pixel[c*CW +: CW]);
    assign avg_data[c*CW +: CW] = quad[CW+1:2];
  end

  always_comb begin
    state_d    = state_q;
    fin_d      = fin_q;
    hold_d     = hold_q;
    mem_we_d   = 1'b0;
    done_d     = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    lb_we      = 1'b0;
    lb_re      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          fin_d   = 1'b0;
          hold_d  = '0;
        end
      end
      S_RUN: begin
        if (fin_q) begin
          state_d = S_IDLE;
        end else if (accept) begin
          if (!x[0]) begin
            hold_d = pixel;
            lb_re  = y[0];
          end else if (!y[0]) begin
            lb_we = 1'b1;
          end else begin
            mem_we_d   = 1'b1;
            mem_addr_d = ADDR_W'(y[7:1]) * ADDR_W'(HALF_W) + ADDR_W'(x[7:1]);
            mem_data_d = avg_data;
            if (last_beat) begin
              done_d = 1'b1;
              fin_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fin_q      <= 1'b0;
      hold_q     <= '0;
      mem_we_q   <= 1'b0;
      done_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      fin_q      <= fin_d;
      hold_q     <= hold_d;
      mem_we_q   <= mem_we_d;
      done_q     <= done_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Line buffer holds even-row pair sums; never cleared, each even row rewrites it
  always_ff @(posedge clk) begin
    if (lb_we) lb_mem[lb_idx] <= lb_wdata;
    if (lb_re) lb_rd_q <= lb_mem[lb_idx];
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign done     = done_q;
  assign busy     = (state_q == S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_frame_downsample_writer.sv
// Self-checking bench for frame_downsample_writer on a 4x4 frame.
`default_nettype none

module tb_frame_downsample_writer;
  localparam int IN_W = 4, IN_H = 4, CW = 10, ADDR_W = 2, PW = 30;

  logic              clk = 1'b0;
  logic              reset, start, write;
  logic [7:0]        x, y;
  logic [PW-1:0]     pixel;
  logic              mem_we, busy, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [PW-1:0]     mem_data;

  frame_downsample_writer #(.IN_W(IN_W), .IN_H(IN_H), .CW(CW), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .write(write), .x(x), .y(y),
    .pixel(pixel), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PW-1:0]     data;
    logic              dn;
  } exp_t;

  int            checks = 0, failures = 0, nwr = 0;
  exp_t          expq[$];
  exp_t          ecmp;
  logic          dn_prev = 1'b0;
  logic [PW-1:0] cap [4];
  logic [PW-1:0] frm [IN_H][IN_W];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic logic [PW-1:0] px(input int r, input int g, input int b);
    return {10'(r), 10'(g), 10'(b)};
  endfunction

  // Reference: per-channel integer mean of four pixels, truncated
  function automatic logic [PW-1:0] avg4(input logic [PW-1:0] a, b, c, d);
    logic [PW-1:0] r;
    for (int ch = 0; ch < 3; ch++) begin
      int s;
      s = int'(a[ch*CW +: CW]) + int'(b[ch*CW +: CW]) + int'(c[ch*CW +: CW]) + int'(d[ch*CW +: CW]);
      r[ch*CW +: CW] = 10'(s / 4);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      dn_prev = 1'b0;
    end else begin
      if (dn_prev) chk("busy_after_done", 64'(busy), 64'd0);
      dn_prev = done;
      if (mem_we) begin
        nwr++;
        if (expq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: addr %0d data %0h, required no write", mem_addr, mem_data);
        end else begin
          ecmp = expq.pop_front();
          chk("mem_addr", 64'(mem_addr), 64'(ecmp.addr));
          chk("mem_data", 64'(mem_data), 64'(ecmp.data));
          chk("done_with_we", 64'(done), 64'(ecmp.dn));
          chk("busy_during_write", 64'(busy), 64'd1);
          cap[mem_addr] = mem_data;
        end
      end else begin
        chk("done_without_we", 64'(done), 64'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic beat(input int bx, input int by, input logic [PW-1:0] p);
    write = 1'b1; x = 8'(bx); y = 8'(by); pixel = p;
    cyc();
    write = 1'b0;
  endtask

  task automatic push_expect(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      int bx = k % 2, by = k / 2;
      e.addr = ADDR_W'(k);
      e.data = avg4(frm[2*by][2*bx], frm[2*by][2*bx+1], frm[2*by+1][2*bx], frm[2*by+1][2*bx+1]);
      e.dn   = (k == 3);
      expq.push_back(e);
    end
  endtask

  task automatic send_beats(input int first, input int last, input bit gaps, input bit junk);
    for (int i = first; i <= last; i++) begin
      int xx = i % IN_W, yy = i / IN_W;
      if (gaps) repeat ($urandom_range(0, 2)) cyc();
      if (junk) beat((i % 2) ? 4 : xx, (i % 2) ? yy : 4, PW'($urandom));
      beat(xx, yy, frm[yy][xx]);
    end
  endtask

  task automatic do_start(input bit with_beat);
    start = 1'b1;
    if (with_beat) begin write = 1'b1; x = 8'd0; y = 8'd0; pixel = '1; end
    cyc();
    start = 1'b0; write = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (expq.size() != 0 && n < 20) begin cyc(); n++; end
    chk({nm, "_drain"}, 64'(expq.size()), 64'd0);
    cyc(); cyc();
    chk({nm, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic run_frame(input string nm, input bit gaps, input bit junk);
    int w0;
    w0 = nwr;
    push_expect(4);
    do_start(1'b1);
    chk({nm, "_busy_armed"}, 64'(busy), 64'd1);
    send_beats(0, 15, gaps, junk);
    drain(nm);
    chk({nm, "_writes"}, 64'(nwr - w0), 64'd4);
  endtask

  initial begin
    int w0;
    reset = 1'b1; start = 1'b0; write = 1'b0; x = '0; y = '0; pixel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_data", 64'(mem_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Uniform frame; also serves as stream sent while idle (must be ignored)
    for (int r = 0; r < IN_H; r++) for (int c = 0; c < IN_W; c++) frm[r][c] = px(100, 100, 100);
    w0 = nwr;
    send_beats(0, 15, 1'b0, 1'b0);
    cyc();
    chk("gate_idle_writes", 64'(nwr - w0), 64'd0);
    chk("gate_idle_busy", 64'(busy), 64'd0);
    run_frame("uniform", 1'b0, 1'b0);
    chk("uniform_addr3", 64'(cap[3]), 64'(px(100, 100, 100)));

    // Truncation and saturation-free sums
    frm[0][0] = px(1, 5, 0);    frm[0][1] = px(2, 6, 0);
    frm[1][0] = px(2, 7, 0);    frm[1][1] = px(2, 8, 3);
    frm[0][2] = px(3, 10, 1023); frm[0][3] = px(3, 20, 1023);
    frm[1][2] = px(3, 30, 1023); frm[1][3] = px(2, 40, 1022);
    for (int r = 2; r < 4; r++) for (int c = 0; c < 4; c++) frm[r][c] = px(1023, 1023, 1023);
    for (int gap = 0; gap < 2; gap++) begin
      for (int k = 0; k < 4; k++) cap[k] = '0;
      run_frame(gap ? "trunc_gapped" : "trunc", gap[0], 1'b0);
      chk("trunc_blk0", 64'(cap[0]), 64'(px(1, 6, 0)));
      chk("trunc_blk1", 64'(cap[1]), 64'(px(2, 25, 1022)));
      chk("max_blk2", 64'(cap[2]), 64'(px(1023, 1023, 1023)));
      chk("max_blk3", 64'(cap[3]), 64'(px(1023, 1023, 1023)));
    end

    // Out-of-range beats interleaved
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) frm[r][c] = px(r*4 + c, 50*r + c, 900 - 37*c);
    run_frame("range", 1'b1, 1'b1);

    // Reset mid-frame after 10 accepted beats
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) frm[r][c] = px(700, 3*c, 11*r);
    push_expect(2);
    do_start(1'b0);
    send_beats(0, 9, 1'b0, 1'b0);
    chk("midrst_pending", 64'(expq.size()), 64'd0);
    reset = 1'b1;
    cyc();
    chk("midrst_we", 64'(mem_we), 64'd0);
    chk("midrst_addr", 64'(mem_addr), 64'd0);
    chk("midrst_data", 64'(mem_data), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    reset = 1'b0;
    w0 = nwr;
    send_beats(10, 15, 1'b0, 1'b0);
    cyc();
    chk("midrst_no_writes", 64'(nwr - w0), 64'd0);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) frm[r][c] = px(10*r + c, 1000 - r, 2*c);
    run_frame("after_rst", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/frame_downsample_writer.md
# frame_downsample_writer

Downstream stage of the still-frame capture block. It consumes the raster-ordered pixel stream (write strobe, x, y, pixel) that the capture block produces for one video frame. It reduces the frame 2x2 by box-averaging each channel and writes the reduced image into a single-port frame RAM. One `start` arms it for exactly one frame, and `done` reports completion to the controller.

## Interface
Parameters:
- `IN_W`, default 160: input frame width in pixels; even, at most 256.
- `IN_H`, default 120: input frame height in lines; even, at most 256.
- `CW`, default 10: bits per colour channel. Pixel format is {R,G,B}.
- `ADDR_W`, default 13: output RAM address width; must satisfy 2^ADDR_W >= (IN_W/2)*(IN_H/2).

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: arm for one frame. Sampled only in S_IDLE.
- `write` in 1: input pixel valid for this cycle.
- `x` in 8: input pixel column.
- `y` in 8: input pixel row.
- `pixel` in 3*CW: input {R,G,B}.
- `mem_we` out 1: output RAM write enable, one cycle per reduced pixel.
- `mem_addr` out ADDR_W: (y>>1)*(IN_W/2) + (x>>1).
- `mem_data` out 3*CW: averaged {R,G,B}.
- `busy` out 1: high while armed.
- `done` out 1: one-cycle pulse when the final reduced pixel is written.

## Operation
- States are S_IDLE and S_RUN.
  - S_IDLE → S_RUN when `start`=1. In the same cycle, clear the hold register and the internal done flag.
  - S_RUN → S_IDLE in the cycle after the last block is written.
- In S_IDLE, ignore `write`. In S_RUN, ignore `start`.
- An input beat is accepted only if all of these hold: `write`=1, state is S_RUN, x<IN_W, y<IN_H. Any other beat has no effect.
- The input stream must be raster ordered. Behaviour under out-of-order input is unspecified, but must never write outside address range 0..(IN_W/2)*(IN_H/2)-1.
- Even row (y[0]=0):
  - Even x: store the pixel in the hold register.
  - Odd x: compute the per-channel sum hold+pixel (CW+1 bits) and write it to line-buffer entry x>>1.
- Odd row (y[0]=1):
  - Even x: store the pixel in the hold register. Issue a line-buffer read at x>>1.
  - Odd x: per channel, compute (linebuf + hold + pixel) >> 2 using a CW+2-bit sum, truncating (no rounding). Register the result to `mem_data` and the address to `mem_addr`, and pulse `mem_we`.
- Line buffer: IN_W/2 entries × 3*(CW+1) bits, synchronous read, 1 write port. It is never cleared; each even row fully overwrites it before the next odd row reads it.
- The last block is the accepted beat at x=IN_W-1, y=IN_H-1. It asserts `done` together with its `mem_we`.

## Timing
- Reset values: state S_IDLE; `mem_we`=0, `mem_addr`=0, `mem_data`=0, `busy`=0, `done`=0.
- `busy` is 1 from the cycle after `start` is accepted up to and including the `done` cycle. It is 0 the cycle after `done`.
- Latency: `mem_we`, `mem_addr` and `mem_data` are registered and valid exactly 1 cycle after the accepted odd-x/odd-row beat.
- Back-to-back beats (write=1 every cycle) are fully supported. The line-buffer read issued at the even-x beat is used at the odd-x beat, however many cycles later that beat arrives. Gaps between beats are allowed.
- `mem_we` is high for exactly 1 cycle per output pixel. Total per frame is (IN_W/2)*(IN_H/2) writes.
- Reset mid-frame: the next cycle shows all outputs at their reset values. No further `mem_we` until a new `start`. A new frame after reset needs no other recovery.
- `start` and `write` in the same cycle while in S_IDLE: the beat is ignored; capture begins with the next accepted beat.

## Test plan
- IN_W=4, IN_H=4, CW=10. `start`, then 16 back-to-back beats, all pixels {100,100,100} → 4 writes, mem_addr 0,1,2,3, each mem_data {100,100,100}. `done` coincides with the write to address 3. `busy` falls 1 cycle later.
- Truncation: one 2x2 block with R values 1,2,2,2 → R out = 1. A block with R values 3,3,3,2 → R out = 2.
- Overflow: all channels 1023 → every output {1023,1023,1023}. No wrap.
- Gating: 16 beats sent before `start` → zero `mem_we`. `start` then asserted with the stream random-gapped (write duty ~50%) → output identical to the gapless run.
- Range: beats with x=4 or y=4 interleaved into a valid frame → ignored. Exactly 4 writes occur, with correct data.
- Reset after 10 accepted beats → outputs zero next cycle and no writes follow. A full new frame after `start` produces correct averages, with no dependence on the stale line buffer.
